// File: rtl/inst_encoder_loader_pkg.sv
// inst_encoder_loader_pkg: RV32I type codes, opcode/funct constants and the per-type encoding table shared with the decoder
package inst_encoder_loader_pkg;
  localparam int INST_TYPE_WIDTH = 6;
  typedef enum logic [INST_TYPE_WIDTH-1:0] {
    T_LUI, T_AUIPC, T_JAL, T_JALR,
    T_BEQ, T_BNE, T_BLT, T_BGE, T_BLTU, T_BGEU,
    T_LB, T_LH, T_LW, T_LBU, T_LHU,
    T_SB, T_SH, T_SW,
    T_ADDI, T_SLTI, T_SLTIU, T_XORI, T_ORI, T_ANDI, T_SLLI, T_SRLI, T_SRAI,
    T_ADD, T_SUB, T_SLL, T_SLT, T_SLTU, T_XOR, T_SRL, T_SRA, T_OR, T_AND
  } inst_type_e;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
  } enc_t;
  function automatic enc_t enc_lookup(input logic [INST_TYPE_WIDTH-1:0] t);
    enc_t e;
    e = '{FMT_X, 7'd0, 3'd0, 7'd0};
    case (t)
      T_LUI:   e = '{FMT_U,  OP_LUI,    3'd0, 7'd0};
      T_AUIPC: e = '{FMT_U,  OP_AUIPC,  3'd0, 7'd0};
      T_JAL:   e = '{FMT_J,  OP_JAL,    3'd0, 7'd0};
      T_JALR:  e = '{FMT_I,  OP_JALR,   3'd0, 7'd0};
      T_BEQ:   e = '{FMT_B,  OP_BRANCH, 3'd0, 7'd0};
      T_BNE:   e = '{FMT_B,  OP_BRANCH, 3'd1, 7'd0};
      T_BLT:   e = '{FMT_B,  OP_BRANCH, 3'd4, 7'd0};
      T_BGE:   e = '{FMT_B,  OP_BRANCH, 3'd5, 7'd0};
      T_BLTU:  e = '{FMT_B,  OP_BRANCH, 3'd6, 7'd0};
      T_BGEU:  e = '{FMT_B,  OP_BRANCH, 3'd7, 7'd0};
      T_LB:    e = '{FMT_I,  OP_LOAD,   3'd0, 7'd0};
      T_LH:    e = '{FMT_I,  OP_LOAD,   3'd1, 7'd0};
      T_LW:    e = '{FMT_I,  OP_LOAD,   3'd2, 7'd0};
      T_LBU:   e = '{FMT_I,  OP_LOAD,   3'd4, 7'd0};
      T_LHU:   e = '{FMT_I,  OP_LOAD,   3'd5, 7'd0};
      T_SB:    e = '{FMT_S,  OP_STORE,  3'd0, 7'd0};
      T_SH:    e = '{FMT_S,  OP_STORE,  3'd1, 7'd0};
      T_SW:    e = '{FMT_S,  OP_STORE,  3'd2, 7'd0};
      T_ADDI:  e = '{FMT_I,  OP_IMM,    3'd0, 7'd0};
      T_SLTI:  e = '{FMT_I,  OP_IMM,    3'd2, 7'd0};
      T_SLTIU: e = '{FMT_I,  OP_IMM,    3'd3, 7'd0};
      T_XORI:  e = '{FMT_I,  OP_IMM,    3'd4, 7'd0};
      T_ORI:   e = '{FMT_I,  OP_IMM,    3'd6, 7'd0};
      T_ANDI:  e = '{FMT_I,  OP_IMM,    3'd7, 7'd0};
      T_SLLI:  e = '{FMT_SH, OP_IMM,    3'd1, 7'd0};
      T_SRLI:  e = '{FMT_SH, OP_IMM,    3'd5, 7'd0};
      T_SRAI:  e = '{FMT_SH, OP_IMM,    3'd5, F7_ALT};
      T_ADD:   e = '{FMT_R,  OP_REG,    3'd0, 7'd0};
      T_SUB:   e = '{FMT_R,  OP_REG,    3'd0, F7_ALT};
      T_SLL:   e = '{FMT_R,  OP_REG,    3'd1, 7'd0};
      T_SLT:   e = '{FMT_R,  OP_REG,    3'd2, 7'd0};
      T_SLTU:  e = '{FMT_R,  OP_REG,    3'd3, 7'd0};
      T_XOR:   e = '{FMT_R,  OP_REG,    3'd4, 7'd0};
      T_SRL:   e = '{FMT_R,  OP_REG,    3'd5, 7'd0};
      T_SRA:   e = '{FMT_R,  OP_REG,    3'd5, F7_ALT};
      T_OR:    e = '{FMT_R,  OP_REG,    3'd6, 7'd0};
      T_AND:   e = '{FMT_R,  OP_REG,    3'd7, 7'd0};
      default: e = '{FMT_X,  7'd0,      3'd0, 7'd0};
    endcase
    return e;
  endfunction
endpackage

// File: rtl/inst_encoder_loader_pack.sv
// inst_pack: combinational RV32I encoder, (type, rd, rs1, rs2, imm) -> (word, known)
// in_*: decoded tuple; word: packed instruction (0 when unknown); known: type code recognised
module inst_pack
  import inst_encoder_loader_pkg::*;
(
  input  logic [INST_TYPE_WIDTH-1:0] in_type,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [31:0]                in_imm,
  output logic [31:0]                word,
  output logic                       known
);
  enc_t e;
  always_comb begin
    e = enc_lookup(in_type);
    known = e.fmt != FMT_X;
    word =
      e.fmt == FMT_R  ? {e.f7, in_rs2, in_rs1, e.f3, in_rd, e.op} :
      e.fmt == FMT_I  ? {in_imm[11:0], in_rs1, e.f3, in_rd, e.op} :
      e.fmt == FMT_SH ? {e.f7, in_imm[4:0], in_rs1, e.f3, in_rd, e.op} :
      e.fmt == FMT_S  ? {in_imm[11:5], in_rs2, in_rs1, e.f3, in_imm[4:0], e.op} :
      e.fmt == FMT_B  ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, e.f3, in_imm[4:1], in_imm[11], e.op} :
      e.fmt == FMT_U  ? {in_imm[31:12], in_rd, e.op} :
      e.fmt == FMT_J  ? {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, e.op} :
      32'd0;
  end
endmodule

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: encodes an RV32I tuple and writes it little-endian, one byte per cycle, at a running pointer
// ptr_load/ptr_val: pointer load in IDLE; in_*: tuple handshake; mem_*: byte write port;
// word_out: last encoded word; done_out/err_out: completion pulse, err marks an unknown type
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       ptr_load,
  input  logic [ADDR_W-1:0]          ptr_val,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_TYPE_WIDTH-1:0] in_type,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [31:0]                in_imm,
  output logic [ADDR_W-1:0]          mem_a,
  output logic [7:0]                 mem_dout,
  output logic                       mem_wr,
  output logic [31:0]                word_out,
  output logic                       done_out,
  output logic                       err_out
);
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_FIN} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic              err_q, err_d;
  logic [31:0]       enc_word;
  logic              enc_known;
  inst_pack u_pack (
    .in_type (in_type),
    .in_rd   (in_rd),
    .in_rs1  (in_rs1),
    .in_rs2  (in_rs2),
    .in_imm  (in_imm),
    .word    (enc_word),
    .known   (enc_known)
  );
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state_q <= S_IDLE;
      ptr_q   <= START_ADDR;
      cnt_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  // rdy_in low leaves every _d at its _q, which freezes the whole block
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    err_d   = err_q;
    if (rdy_in)
      case (state_q)
        S_IDLE:
          if (ptr_load) ptr_d = ptr_val;
          else if (in_valid) begin
            word_d  = enc_word;
            err_d   = ~enc_known;
            cnt_d   = '0;
            state_d = enc_known ? S_EMIT : S_FIN;
          end
        S_EMIT: begin
          ptr_d   = ptr_q + ADDR_W'(1);
          cnt_d   = cnt_q + 2'd1;
          state_d = cnt_q == 2'd3 ? S_FIN : S_EMIT;
        end
        default: state_d = S_IDLE;
      endcase
  end
  always_comb begin
    in_ready = state_q == S_IDLE && rdy_in;
    mem_wr   = state_q == S_EMIT && rdy_in;
    mem_a    = state_q == S_EMIT ? ptr_q : '0;
    mem_dout = state_q == S_EMIT ? word_q[{cnt_q, 3'b000} +: 8] : 8'd0;
    word_out = word_q;
    done_out = state_q == S_FIN && rdy_in;
    err_out  = state_q == S_FIN && rdy_in && err_q;
  end
endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb_inst_encoder_loader: scoreboard bench for the encoder/loader byte writer
module tb_inst_encoder_loader;
  import inst_encoder_loader_pkg::*;
  logic        clk_in = 0, rst_in = 0, rdy_in = 1, ptr_load = 0, in_valid = 0;
  logic [31:0] ptr_val = 0, in_imm = 0;
  logic [5:0]  in_type = 0;
  logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic        in_ready, mem_wr, done_out, err_out;
  logic [31:0] mem_a, word_out;
  logic [7:0]  mem_dout;
  int          checks = 0, errors = 0;
  logic [39:0] sb[$];
  logic [39:0] e;
  logic [31:0] ptr_m = 0, base_m = 0;
  inst_encoder_loader dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .ptr_load(ptr_load), .ptr_val(ptr_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .word_out(word_out), .done_out(done_out), .err_out(err_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(negedge clk_in)
    if (rst_in && mem_wr) begin
      if (sb.size() == 0) chk("unexp_wr", {31'd0, mem_wr}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("wr_a", mem_a, e[39:8]);
        chk("wr_d", {24'd0, mem_dout}, {24'd0, e[7:0]});
      end
    end
  task automatic load_ptr(input logic [31:0] v);
    ptr_load = 1;
    ptr_val = v;
    @(posedge clk_in); #1;
    ptr_load = 0;
    ptr_m = v;
  endtask
  task automatic start(input logic [5:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp,
                       input bit known);
    in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1;
    base_m = ptr_m;
    if (known) begin
      for (int i = 0; i < 4; i++) sb.push_back({ptr_m + 32'(i), exp[8*i +: 8]});
      ptr_m = ptr_m + 32'd4;
    end
    @(posedge clk_in); #1;
    in_valid = 0;
    chk("word", word_out, exp);
  endtask
  task automatic finish(input bit known, input bit stall);
    int k = 0;
    bit seen = 0;
    while (!seen && k < 20) begin
      k++;
      rdy_in = !(stall && k >= 3 && k <= 5);
      @(negedge clk_in);
      if (done_out) seen = 1;
      else if (!rdy_in) begin
        chk("stall_wr", {31'd0, mem_wr}, 32'd0);
        chk("stall_a", mem_a, base_m + 32'd2);
      end
      if (!seen) begin @(posedge clk_in); #1; end
    end
    rdy_in = 1;
    chk("latency", k, !known ? 32'd1 : stall ? 32'd8 : 32'd5);
    chk("err", {31'd0, err_out}, {31'd0, !known});
    @(posedge clk_in); #1;
    chk("done_pulse", {31'd0, done_out}, 32'd0);
    chk("ready", {31'd0, in_ready}, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);
  endtask
  initial begin
    int dn;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_word", word_out, 32'd0);
    chk("rst_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_done", {30'd0, done_out, err_out}, 32'd0);
    chk("rst_mem", {mem_a[23:0], mem_dout}, 32'd0);
    rst_in = 1;
    @(posedge clk_in); #1;
    ptr_load = 1; ptr_val = 32'h2000; in_valid = 1; in_type = T_ADDI; in_rd = 1; in_imm = 5;
    @(posedge clk_in); #1;
    ptr_load = 0; in_valid = 0;
    chk("prio_ready", {31'd0, in_ready}, 32'd1);
    chk("prio_word", word_out, 32'd0);
    load_ptr(32'h1000);
    start(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1); finish(1, 0);
    start(T_SRAI, 5'd5, 5'd6, 5'd0, 32'h403, 32'h40335293, 1); finish(1, 1);
    start(T_LUI, 5'd2, 5'd0, 5'd0, 32'h12345000, 32'h12345137, 1); finish(1, 0);
    start(T_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 32'hFE208CE3, 1); finish(1, 0);
    start(T_JAL, 5'd1, 5'd0, 5'd0, 32'h800, 32'h001000EF, 1); finish(1, 0);
    start(6'd63, 5'd3, 5'd1, 5'd2, 32'h7, 32'h0, 0); finish(0, 0);
    start(T_SUB, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 1); finish(1, 0);
    load_ptr(32'hFFFFFFFE);
    start(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1); finish(1, 0);
    load_ptr(32'hFFFFFFFE);
    start(T_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1);
    @(negedge clk_in);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    @(posedge clk_in); #1;
    rst_in = 0;
    #1;
    chk("midrst_wr", {31'd0, mem_wr}, 32'd0);
    chk("midrst_a", mem_a, 32'd0);
    sb.delete();
    ptr_m = 0;
    dn = 0;
    repeat (2) begin @(negedge clk_in); dn += int'(done_out); end
    @(posedge clk_in); #1;
    rst_in = 1;
    repeat (4) begin @(negedge clk_in); dn += int'(done_out); end
    chk("midrst_nodone", dn, 32'd0);
    @(posedge clk_in); #1;
    start(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1); finish(1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the instruction decoder: takes a decoded RV32I tuple (type, rd, rs1, rs2, imm) and packs it into a 32-bit instruction word.
- Writes that word little-endian, one byte per cycle, over the byte-wide RAM write port, at a running write pointer.
- Used by the debug/boot path to place programs into memory and by the bench to generate stimulus.
- Type codes and field layout are shared with the decoder, so a decode→encode round trip is bit-exact for canonical encodings.

Parameters:
ADDR_W, 32, width of the write pointer and mem_a
START_ADDR, 32'h0, pointer value after reset

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; 0 freezes all state, mem_wr forced 0
ptr_load  input  1  load write pointer from ptr_val (honoured only in IDLE)
ptr_val  input  ADDR_W  new pointer value
in_valid  input  1  tuple valid
in_ready  output  1  1 only in IDLE with rdy_in=1
in_type  input  `INST_TYPE_WIDTH  instruction type code (shared constants)
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  32  immediate, sign-extended byte/word offset as produced by the decoder
mem_a  output  ADDR_W  byte address
mem_dout  output  8  byte data
mem_wr  output  1  write strobe
word_out  output  32  last encoded word, held until next accept
done_out  output  1  one-cycle pulse after a tuple completes
err_out  output  1  one-cycle pulse with done_out for an unknown type

Behaviour:
- Reset (rst_in=0, async): state=IDLE, ptr=START_ADDR, byte count=0, word_out=0; mem_wr, done_out, err_out=0; mem_a=0, mem_dout=0.
- States:
  - IDLE: in_ready=1. ptr_load has priority over in_valid in the same cycle; both → load pointer, accept nothing.
  - Accept when in_valid & in_ready: fields registered, word encoded the same cycle into word_out, next state EMIT with cnt=0.
  - EMIT: each cycle with rdy_in=1, drive mem_wr=1, mem_a=ptr, mem_dout=word[8*cnt+7:8*cnt]; then ptr+=1 (wraps mod 2^ADDR_W) and cnt+=1. After cnt=3 → FIN.
  - FIN: done_out=1 for one cycle → IDLE.
- Latency: accept at T → bytes at T+1..T+4 → done_out at T+5 (no stalls). Throughput is one tuple per 6 cycles.
- rdy_in=0 in any state: nothing advances; mem_wr=0; outputs hold; pulses delayed, not lost.
- Unknown type: accept, word_out=0, EMIT skipped, pointer unchanged, FIN asserts done_out and err_out together.
- Encoding: opcode and funct3/funct7 from shared constants.
  - R: f7|rs2|rs1|f3|rd|op.
  - I (JALR, loads, ALU-imm): imm[11:0].
  - SLLI/SRLI/SRAI: imm[4:0] as shamt; f7 = 0x00, or 0x20 for SRAI; in_imm[11:5] ignored.
  - S: imm[11:5], imm[4:0].
  - B: imm[12|10:5], imm[4:1|11]; imm[0] ignored.
  - U: imm[31:12].
  - J: imm[20|10:1|11|19:12]; imm[0] ignored.
  - Out-of-range immediate bits are silently truncated; no range check.
  - Unused register fields are driven from inputs unchanged.
- Reset mid-EMIT: partial word abandoned, pointer returns to START_ADDR, no done_out.

Decomposition:
- Shared header (info.v): type codes, `INST_TYPE_WIDTH, new opcode/funct3/funct7 constants per type.
- Sub-module inst_pack: purely combinational (type, rd, rs1, rs2, imm) → (word, known). The FSM, pointer and byte counter stay in the top.

Test Plan:
- ptr_load 0x1000, then ADDI x1,x0,5 → word_out 0x00500093; bytes 93,00,50,00 at 0x1000–0x1003; done_out at T+5; next pointer 0x1004.
- SRAI x5,x6,3 with in_imm=0x403 → 0x40335293; LUI x2,imm 0x12345000 → 0x12345137.
- BEQ x1,x2,imm=0xFFFFFFF8 → 0xFE208CE3; JAL x1,imm=0x800 → 0x001000EF.
- rdy_in low for 3 cycles after the second byte → mem_wr=0 and mem_a/pointer held during the stall; remaining bytes resume in order; done_out delayed by exactly 3 cycles.
- Unknown type code → no mem_wr; pointer unchanged; done_out=err_out=1 for one cycle; in_ready returns to 1.
- Pointer 0xFFFFFFFE with one tuple → writes at FFFFFFFE, FFFFFFFF, 0, 1; reset asserted during byte 2 → mem_wr drops immediately; pointer=START_ADDR; no done_out.
